// File: rtl/dff_en_pkg.sv
// Shared constants for the enabled D flip-flop slice.
`timescale 1ns/100ps
package dff_en_pkg;

  localparam int unsigned DFF_EN_DEF_WIDTH = 1;

endpackage

// File: rtl/dff_r.sv
// Plain rising-edge D flip-flop with synchronous active-high reset.
`timescale 1ns/100ps
module dff_r #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_en.sv
// Enabled D register: a hold/load mux in front of a reset flop; q comes straight from the flop.
`timescale 1ns/100ps
module dff_en
  import dff_en_pkg::*;
#(
  parameter int unsigned      WIDTH   = DFF_EN_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] next_c;

  // Recirculate q when disabled; one enable covers every bit.
  assign next_c = en ? d : q;

  dff_r #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_dff_r (
    .clk (clk),
    .rst (rst),
    .d   (next_c),
    .q   (q)
  );

endmodule

// File: tb/tb_dff_en.sv
// Directed bench for dff_en: a 1-bit and an 8-bit/A5-reset instance against a behavioural model.
`timescale 1ns/100ps
module tb_dff_en;

  logic       clk = 1'b0;
  logic       rst1, en1, d1, q1;
  logic       rst8, en8;
  logic [7:0] d8, q8;

  logic       exp1;
  logic [7:0] exp8;
  bit         v1 = 1'b0;
  bit         v8 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  dff_en u_dut1 (
    .clk (clk),
    .rst (rst1),
    .en  (en1),
    .d   (d1),
    .q   (q1)
  );

  dff_en #(
    .WIDTH   (8),
    .RST_VAL (8'hA5)
  ) u_dut8 (
    .clk (clk),
    .rst (rst8),
    .en  (en8),
    .d   (d8),
    .q   (q8)
  );

  always #7.5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model; q is only defined once a reset or load has happened.
  always @(posedge clk) begin
    if (rst1) begin
      exp1 <= 1'b0;
      v1   <= 1'b1;
    end else if (en1) begin
      exp1 <= d1;
      v1   <= 1'b1;
    end
    if (rst8) begin
      exp8 <= 8'hA5;
      v8   <= 1'b1;
    end else if (en8) begin
      exp8 <= d8;
      v8   <= 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (v1) check("model_w1", 8'(q1), 8'(exp1));
    if (v8) check("model_w8", q8, exp8);
  end

  initial begin
    rst1 = 1'b1; en1 = 1'b0; d1 = 1'b0;
    rst8 = 1'b1; en8 = 1'b0; d8 = 8'h00;

    // Enabled load with d toggling off-edge
    @(posedge clk); #1;
    check("w1_reset", 8'(q1), 8'h00);
    rst1 = 1'b0; en1 = 1'b1;
    repeat (5) begin
      #12 d1 = ~d1;
    end

    // Hold: load 1, then disable and toggle d
    @(negedge clk); d1 = 1'b1; en1 = 1'b1;
    @(posedge clk); #1;
    check("hold_load", 8'(q1), 8'h01);
    en1 = 1'b0;
    repeat (6) begin
      #12 d1 = ~d1;
    end
    @(posedge clk); #1;
    check("hold_end", 8'(q1), 8'h01);

    // Reset beats enable
    @(negedge clk); en1 = 1'b1; d1 = 1'b1; rst1 = 1'b1;
    @(posedge clk); #1;
    check("rst_prio", 8'(q1), 8'h00);
    @(negedge clk); rst1 = 1'b0;
    @(posedge clk); #1;
    check("rst_release", 8'(q1), 8'h01);

    // Data pulse wholly between edges
    @(negedge clk); d1 = 1'b0;
    @(posedge clk); #1;
    check("imm_a", 8'(q1), 8'h00);
    #2 d1 = 1'b1;
    #3 d1 = 1'b0;
    @(posedge clk); #1;
    check("imm_b", 8'(q1), 8'h00);

    // Reset pulse wholly between edges
    @(negedge clk); d1 = 1'b1;
    @(posedge clk); #1;
    check("rstg_load", 8'(q1), 8'h01);
    en1 = 1'b0;
    #2 rst1 = 1'b1;
    #3 rst1 = 1'b0;
    @(posedge clk); #1;
    check("rstg_hold", 8'(q1), 8'h01);

    // 8-bit instance with non-zero reset value
    @(negedge clk); rst8 = 1'b1;
    @(posedge clk); #1;
    check("w8_reset", q8, 8'hA5);
    @(negedge clk); rst8 = 1'b0; en8 = 1'b0; d8 = 8'hFF;
    @(posedge clk); #1;
    check("w8_hold_rstval", q8, 8'hA5);
    @(negedge clk); en8 = 1'b1; d8 = 8'h3C;
    @(posedge clk); #1;
    check("w8_load", q8, 8'h3C);
    @(negedge clk); en8 = 1'b0; d8 = 8'hFF;
    @(posedge clk); #1;
    check("w8_hold", q8, 8'h3C);
    @(negedge clk); en8 = 1'b1; d8 = 8'h3C;
    @(posedge clk); #1;
    check("w8_same", q8, 8'h3C);
    @(negedge clk); d8 = 8'h5A;
    @(posedge clk); #1;
    check("w8_load2", q8, 8'h5A);
    @(negedge clk); rst8 = 1'b1; en8 = 1'b1; d8 = 8'h00;
    @(posedge clk); #1;
    check("w8_rst_prio", q8, 8'hA5);
    @(negedge clk); rst8 = 1'b0; en8 = 1'b1; d8 = 8'hC3;
    @(posedge clk); #1;
    check("w8_resume", q8, 8'hC3);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_en.md
DFF_EN -- requirements
Module: dff_en

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, meaning the data width in bits of d and q.
REQ-002 The block SHALL have parameter RST_VAL, default all-zeros (WIDTH bits), meaning the value loaded into q on reset.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset: synchronous, active-high.
REQ-005 The block SHALL have port en, input, 1 bit, the load enable, active-high.
REQ-006 The block SHALL have port d, input, WIDTH bits, the data to capture.
REQ-007 The block SHALL have port q, output, WIDTH bits, the registered data.

Function
REQ-008 On a rising clk edge with rst=0 and en=1, q SHALL take the value of d sampled at that edge.
REQ-009 On a rising clk edge with rst=0 and en=0, q SHALL hold its previous value.
REQ-010 Changes on d or en between rising edges SHALL NOT affect q; there is no transparent or latch path.
REQ-011 Latency SHALL be one clock: d sampled at edge N appears on q immediately after edge N and is stable until at least edge N+1.
REQ-012 q SHALL be driven directly from the storage element with no combinational logic after the flop.
REQ-013 The block SHALL have no falling-edge behaviour.
REQ-014 All WIDTH bits SHALL share the single en; there is no per-bit enable.
REQ-015 If en=1 and d equals q, q SHALL stay unchanged with no glitch.

Reset
REQ-016 On a rising clk edge with rst=1, q SHALL become RST_VAL regardless of en and d.
REQ-017 rst SHALL have priority over en.
REQ-018 Asserting or deasserting rst between clock edges SHALL have no effect until the next rising edge.
REQ-019 On the first rising edge with rst=0 after reset, normal operation SHALL resume: load if en=1, hold RST_VAL if en=0.
REQ-020 Before the first reset or enabled load, q is undefined, and the bench SHALL NOT check q in that window.

Structure
REQ-021 WIDTH and RST_VAL SHALL be module parameters; no shared package is required.
REQ-022 The block SHALL be built as a 2:1 enable multiplexer, next = en ? d : q, feeding one sub-module dff_r, a plain rising-edge D flip-flop with synchronous active-high reset, parameterised by WIDTH and RST_VAL.
REQ-023 The implementation SHALL be synthesizable, with no initial blocks or delays.

Verification
REQ-024 Bench clock period SHALL be 15 ns, with clk starting at 0; the bench SHALL compare q against a reference model at every rising edge.
REQ-025 Enabled load: rst=1 for one edge, then rst=0, en=1, d toggling 0/1 every 12 ns for 5 toggles -> after each rising edge, q equals the d sampled at that edge.
REQ-026 Hold: load q=1 with en=1, then set en=0 and toggle d every 12 ns for 6 toggles -> q stays 1 across every edge.
REQ-027 Reset priority: q=1, then en=1, d=1, rst=1 at an edge -> q=0 after that edge; rst=0 at the next edge with d=1 -> q=1.
REQ-028 Between-edge immunity: pulse d 0->1->0 entirely between two rising edges with en=1 -> q remains 0 at both edges.
REQ-029 Width and reset value: WIDTH=8, RST_VAL=8'hA5, reset -> q=8'hA5; en=1, d=8'h3C -> q=8'h3C; en=0, d=8'hFF -> q stays 8'h3C.
